// File: rtl/ft_pkg.sv
// Shared types and helpers for the FT2232H 245 synchronous FIFO controller.
package ft_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRxOe,
    StRxRd,
    StTurn,
    StTxWr
  } ft_state_e;

  localparam int unsigned DATA_BUS = 8;

  function automatic int unsigned CLOG2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/ft_skid_fifo.sv
// Small synchronous FIFO absorbing rx bytes still in flight when RD is released.
module ft_skid_fifo
  import ft_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_BUS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [CLOG2(DEPTH):0]      free
);

  localparam int unsigned AW = CLOG2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_push = push & (cnt_q != CW'(DEPTH));
  assign do_pop  = pop & (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign free  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/ft245_sync_ctrl.sv
// FT2232H 245 synchronous FIFO controller: half-duplex DBUS arbitration between rx and tx streams.
// Optional send-immediate flush after tx idle is enabled by defining FT_SIWU_EN.
module ft245_sync_ctrl
  import ft_pkg::*;
#(
  parameter int unsigned DATA       = DATA_BUS,
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned SIWU_IDLE  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  inout  wire [DATA-1:0]  DBUS,
  input  logic            RXF,
  input  logic            TXE,
  output logic            RD,
  output logic            WR,
  output logic            OE,
  output logic            SIWU,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  input  logic [DATA-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready
);

  localparam int unsigned BurstW = CLOG2(MAX_BURST + 1);
  localparam int unsigned FreeW  = CLOG2(SKID_DEPTH) + 1;

  ft_state_e         state_q, state_d;
  logic              oe_q, rd_q, wr_q, run_q;
  logic              last_tx_q, last_tx_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA-1:0]   hold_data_q, hold_data_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [FreeW-1:0]  free, free_after;
  logic              fifo_empty, rx_xfer, tx_xfer, tx_load, tx_pending, burst_hit;

  // RD low with RXF low captures a byte, including the TURN cycle if still in flight.
  assign rx_xfer    = ~rd_q & ~RXF;
  assign tx_xfer    = (state_q == StTxWr) & ~wr_q & ~TXE;
  assign tx_ready   = run_q & (~hold_valid_q | tx_xfer);
  assign tx_load    = tx_valid & tx_ready;
  assign tx_pending = hold_valid_q | tx_valid;
  assign free_after = free - FreeW'(rx_xfer);
  assign burst_hit  = (burst_q + BurstW'(rx_xfer | tx_xfer)) == BurstW'(MAX_BURST);

  ft_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (DATA)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_xfer),
    .push_data (DBUS),
    .pop       (rx_valid & rx_ready),
    .head      (rx_data),
    .empty     (fifo_empty),
    .free      (free)
  );

  assign rx_valid = ~fifo_empty;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (tx_load) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
    end else if (tx_xfer) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_tx_d = last_tx_q;
    burst_d   = burst_q + BurstW'(rx_xfer | tx_xfer);
    unique case (state_q)
      StIdle: begin
        burst_d = '0;
        // Rx wins unless it was served last and tx has work waiting.
        if (!RXF && free >= FreeW'(3) && (last_tx_q || !tx_pending)) begin
          state_d   = StRxOe;
          last_tx_d = 1'b0;
        end else if (!TXE && tx_pending) begin
          state_d   = StTxWr;
          last_tx_d = 1'b1;
        end
      end
      StRxOe: state_d = StRxRd;
      StRxRd: begin
        if (RXF || free_after <= FreeW'(2) || burst_hit) state_d = StTurn;
      end
      StTurn: state_d = StIdle;
      StTxWr: begin
        if (TXE || !hold_valid_d || burst_hit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      oe_q         <= 1'b1;
      rd_q         <= 1'b1;
      wr_q         <= 1'b1;
      run_q        <= 1'b0;
      last_tx_q    <= 1'b1;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      oe_q         <= ~((state_d == StRxOe) || (state_d == StRxRd));
      rd_q         <= ~(state_d == StRxRd);
      wr_q         <= ~((state_d == StTxWr) && hold_valid_d);
      run_q        <= 1'b1;
      last_tx_q    <= last_tx_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      burst_q      <= burst_d;
    end
  end

  assign DBUS = (state_q == StTxWr) ? hold_data_q : {DATA{1'bz}};
  assign OE   = oe_q;
  assign RD   = rd_q;
  assign WR   = wr_q;

`ifdef FT_SIWU_EN
  localparam int unsigned SiwuW = CLOG2(SIWU_IDLE + 1);

  logic             siwu_q, armed_q;
  logic [SiwuW-1:0] idle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      siwu_q  <= 1'b1;
      armed_q <= 1'b0;
      idle_q  <= '0;
    end else begin
      siwu_q <= 1'b1;
      if (tx_xfer) begin
        idle_q  <= '0;
        armed_q <= (state_d != StTxWr) & ~hold_valid_d;
      end else if (state_q == StTxWr || tx_valid) begin
        idle_q <= '0;
      end else if (armed_q) begin
        if (idle_q == SiwuW'(SIWU_IDLE - 1)) begin
          siwu_q  <= 1'b0;
          armed_q <= 1'b0;
          idle_q  <= '0;
        end else begin
          idle_q <= idle_q + SiwuW'(1);
        end
      end
    end
  end

  assign SIWU = siwu_q;
`else
  logic unused_siwu_idle;
  assign unused_siwu_idle = (SIWU_IDLE == 0);
  assign SIWU = 1'b1;
`endif

endmodule

// File: tb/tb_ft245_sync_ctrl.sv
// Directed bench for ft245_sync_ctrl with a cycle-level FT2232H FIFO model.
module tb_ft245_sync_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       RXF = 1'b1, TXE = 1'b1;
  logic       RD, WR, OE, SIWU;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_valid, tx_ready;
  logic       rx_ready = 1'b0;
  logic [7:0] ft_data = 8'h00;
  wire  [7:0] dbus;

  assign dbus = (OE == 1'b0) ? ft_data : 8'bz;

  ft245_sync_ctrl #(
    .DATA       (8),
    .MAX_BURST  (4),
    .SKID_DEPTH (8),
    .SIWU_IDLE  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .DBUS     (dbus),
    .RXF      (RXF),
    .TXE      (TXE),
    .RD       (RD),
    .WR       (WR),
    .OE       (OE),
    .SIWU     (SIWU),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] host_q[$], got_q[$], src_q[$], ft_got_q[$];
  int runs_q[$];
  int run_len = 0;
  bit run_tx = 1'b0;
  int cyc = 0, first_rd_cyc = -1, last_wr_cyc = -1, siwu_cyc = -1, siwu_lows = 0;
  int wr_viol = 0, oe_wr_viol = 0;
  bit txe_prev = 1'b1;

  task automatic refresh();
    RXF      = (host_q.size() == 0);
    ft_data  = (host_q.size() > 0) ? host_q[0] : 8'h00;
    tx_valid = (src_q.size() > 0);
    tx_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  task automatic log_dir(input bit is_tx);
    if (run_len > 0 && is_tx != run_tx) begin
      runs_q.push_back(run_tx ? 100 + run_len : run_len);
      run_len = 0;
    end
    run_tx = is_tx;
    run_len++;
  endtask

  // FT2232 model: sample on the rising edge, update its own outputs 1 time unit later.
  always @(posedge clk) begin
    bit rdx, wrx, popx, accx;
    logic [7:0] wd, rb;
    cyc++;
    rdx  = !RD && !RXF;
    wrx  = !WR && !TXE;
    popx = rx_valid && rx_ready;
    accx = tx_valid && tx_ready;
    wd   = dbus;
    rb   = rx_data;
    if (TXE && txe_prev && !WR) wr_viol++;
    txe_prev = TXE;
    if (!OE && !WR) oe_wr_viol++;
    #1;
    if (rdx) begin
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (host_q.size() > 0) void'(host_q.pop_front());
      log_dir(1'b0);
    end
    if (wrx) begin
      ft_got_q.push_back(wd);
      last_wr_cyc = cyc;
      log_dir(1'b1);
    end
    if (popx) got_q.push_back(rb);
    if (accx && src_q.size() > 0) void'(src_q.pop_front());
    if (!SIWU) begin
      siwu_lows++;
      siwu_cyc = cyc;
    end
    refresh();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    refresh();
    #1 rst_n = 1'b0;
    #2;
    check("rst_oe", OE, 1'b1);
    check("rst_rd", RD, 1'b1);
    check("rst_wr", WR, 1'b1);
    check("rst_siwu", SIWU, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Rx stream of 10 bytes with downstream always ready.
    rx_ready = 1'b1;
    c0 = cyc;
    first_rd_cyc = -1;
    for (int i = 0; i < 10; i++) host_q.push_back(8'(i));
    refresh();
    @(negedge clk);
    check("rx_oe_edge1", OE, 1'b0);
    check("rx_rd_edge1", RD, 1'b1);
    @(negedge clk);
    check("rx_rd_edge2", RD, 1'b0);
    @(negedge clk);
    check("rx_valid_edge3", rx_valid, 1'b1);
    check("rx_data_edge3", rx_data, 8'h00);
    check("rx_first_cap", first_rd_cyc - c0, 3);
    for (int i = 0; i < 200 && got_q.size() < 10; i++) @(negedge clk);
    check("rx10_count", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check("rx10_byte", got_q[i], 8'(i));

    // Backpressure: skid must stop RD with reserve left, then deliver everything in order.
    got_q.delete();
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) host_q.push_back(8'h10 + 8'(i));
    refresh();
    repeat (30) @(negedge clk);
    check("bp_rd_high", RD, 1'b1);
    check("bp_host_left", host_q.size(), 2);
    check("bp_rx_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    for (int i = 0; i < 200 && got_q.size() < 8; i++) @(negedge clk);
    check("bp_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("bp_byte", got_q[i], 8'h10 + 8'(i));

    // Tx burst with TXE high for two cycles mid-burst.
    ft_got_q.delete();
    TXE = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'hA0 + 8'(i));
    refresh();
    @(negedge clk);
    check("tx_wr_low", WR, 1'b0);
    @(negedge clk);
    check("tx_first_xfer", ft_got_q.size(), 1);
    TXE = 1'b1;
    repeat (2) @(negedge clk);
    TXE = 1'b0;
    for (int i = 0; i < 100 && ft_got_q.size() < 5; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("tx_count", ft_got_q.size(), 5);
    for (int i = 0; i < 5 && i < ft_got_q.size(); i++) check("tx_byte", ft_got_q[i], 8'hA0 + 8'(i));
    check("tx_wr_while_txe", wr_viol, 0);

    // Both directions saturated: 4-byte bursts alternate, rx first since tx was served last.
    got_q.delete();
    ft_got_q.delete();
    runs_q.delete();
    run_len = 0;
    for (int i = 0; i < 12; i++) begin
      host_q.push_back(8'h30 + 8'(i));
      src_q.push_back(8'hC0 + 8'(i));
    end
    refresh();
    for (int i = 0; i < 300 && (got_q.size() < 12 || ft_got_q.size() < 12); i++) @(negedge clk);
    runs_q.push_back(run_tx ? 100 + run_len : run_len);
    check("arb_runs", runs_q.size(), 6);
    for (int i = 0; i < 6 && i < runs_q.size(); i++) check("arb_run", runs_q[i], (i % 2) ? 104 : 4);
    check("arb_rx_count", got_q.size(), 12);
    check("arb_tx_count", ft_got_q.size(), 12);
    if (got_q.size() == 12) check("arb_rx_last", got_q[11], 8'h3B);
    if (ft_got_q.size() == 12) check("arb_tx_last", ft_got_q[11], 8'hCB);
    check("oe_with_wr", oe_wr_viol, 0);

    // Reset asserted while RD is low.
    got_q.delete();
    for (int i = 0; i < 8; i++) host_q.push_back(8'h50 + 8'(i));
    refresh();
    for (int i = 0; i < 20 && RD !== 1'b0; i++) @(negedge clk);
    check("mid_rd_low", RD, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", OE, 1'b1);
    check("mid_rst_rd", RD, 1'b1);
    check("mid_rst_wr", WR, 1'b1);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_tx_ready", tx_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_oe", OE, 1'b0);
    check("restart_rd", RD, 1'b1);
    for (int i = 0; i < 200 && got_q.size() < 8; i++) @(negedge clk);
    check("restart_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("restart_byte", got_q[i], 8'h50 + 8'(i));

    // Single write then idle: send-immediate behaviour.
    ft_got_q.delete();
`ifdef FT_SIWU_EN
    siwu_lows = 0;
    siwu_cyc  = -1;
`endif
    src_q.push_back(8'hE5);
    refresh();
    repeat (40) @(negedge clk);
    check("siwu_tx_count", ft_got_q.size(), 1);
`ifdef FT_SIWU_EN
    check("siwu_pulses", siwu_lows, 1);
    check("siwu_delay", siwu_cyc - last_wr_cyc, 16);
`else
    check("siwu_never_low", siwu_lows, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
